// File: rtl/end_game_ctrl.sv
// End-of-game sequencer: holds the win/lose screens and drives a stretched active-low global restart.
// Define END_GAME_AUTO_RESTART_EN to let WIN_WAIT restart by itself after WIN_TIMEOUT_CYCLES.
module end_game_ctrl #(
  parameter int LOSE_HOLD_CYCLES   = 50_000_000,
  parameter int RST_PULSE_CYCLES   = 4,
  parameter int WIN_TIMEOUT_CYCLES = 500_000_000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       enable,
  input  logic       keyPressed,
  input  logic [1:0] registradores,
  output logic       rstnGlobal,
  output logic       showWin,
  output logic       showLose,
  output logic       busy
);

  localparam int MAX_LP = (LOSE_HOLD_CYCLES > RST_PULSE_CYCLES) ? LOSE_HOLD_CYCLES : RST_PULSE_CYCLES;
  localparam int MAX_ALL = (MAX_LP > WIN_TIMEOUT_CYCLES) ? MAX_LP : WIN_TIMEOUT_CYCLES;
  localparam int CW = $clog2(MAX_ALL) + 1;

  localparam logic [CW-1:0] ONE        = CW'(1);
  localparam logic [CW-1:0] LOSE_LOAD  = CW'(LOSE_HOLD_CYCLES - 1);
  localparam logic [CW-1:0] PULSE_LOAD = CW'(RST_PULSE_CYCLES - 1);
`ifdef END_GAME_AUTO_RESTART_EN
  localparam logic [CW-1:0] WIN_LOAD   = CW'(WIN_TIMEOUT_CYCLES - 1);
`endif

  typedef enum logic [1:0] {IDLE, WIN_WAIT, LOSE_HOLD, RST_PULSE} state_t;

  state_t        state;
  state_t        stateNext;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cntNext;
  logic          key_q;
  logic          key_edge;
  logic          rstnGlobalD;
  logic          showWinD;
  logic          showLoseD;
  logic          busyD;

  assign key_edge = keyPressed & ~key_q;

  // Outputs are registered from the current state, so they trail each transition by one cycle.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= IDLE;
      cnt        <= '0;
      key_q      <= 1'b0;
      rstnGlobal <= 1'b1;
      showWin    <= 1'b0;
      showLose   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= stateNext;
      cnt        <= cntNext;
      key_q      <= keyPressed;
      rstnGlobal <= rstnGlobalD;
      showWin    <= showWinD;
      showLose   <= showLoseD;
      busy       <= busyD;
    end
  end

  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    case (state)
      IDLE: begin
        if (enable && registradores == 2'b10) begin
          stateNext = LOSE_HOLD;
          cntNext   = LOSE_LOAD;
        end else if (enable && registradores == 2'b01) begin
          stateNext = WIN_WAIT;
`ifdef END_GAME_AUTO_RESTART_EN
          cntNext   = WIN_LOAD;
`endif
        end
      end
      LOSE_HOLD: begin
        if (!enable) begin
          stateNext = IDLE;
        end else if (cnt == '0) begin
          stateNext = RST_PULSE;
          cntNext   = PULSE_LOAD;
        end else begin
          cntNext = cnt - ONE;
        end
      end
      WIN_WAIT: begin
        // A key held on entry has key_q already set, so only a fresh press restarts.
        if (!enable) begin
          stateNext = IDLE;
`ifdef END_GAME_AUTO_RESTART_EN
        end else if (key_edge || cnt == '0) begin
          stateNext = RST_PULSE;
          cntNext   = PULSE_LOAD;
        end else begin
          cntNext = cnt - ONE;
        end
`else
        end else if (key_edge) begin
          stateNext = RST_PULSE;
          cntNext   = PULSE_LOAD;
        end
`endif
      end
      RST_PULSE: begin
        if (cnt == '0) begin
          stateNext = IDLE;
        end else begin
          cntNext = cnt - ONE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    rstnGlobalD = 1'b1;
    showWinD    = 1'b0;
    showLoseD   = 1'b0;
    busyD       = (state != IDLE);
    case (state)
      WIN_WAIT:  showWinD    = 1'b1;
      LOSE_HOLD: showLoseD   = 1'b1;
      RST_PULSE: rstnGlobalD = 1'b0;
      default:   ;
    endcase
  end

endmodule

// File: tb/tb_end_game_ctrl.sv
// Self-checking bench for end_game_ctrl: directed scenarios plus randomized traffic
// against a queue-based schedule model of the expected output frames.
module tb_end_game_ctrl;

  localparam int LH = 5;
  localparam int RP = 3;
  localparam int WT = 8;

  // Output frame code: {~rstnGlobal, showLose, showWin, busy}
  localparam logic [3:0] C_IDLE  = 4'b0000;
  localparam logic [3:0] C_WIN   = 4'b0011;
  localparam logic [3:0] C_LOSE  = 4'b0101;
  localparam logic [3:0] C_PULSE = 4'b1001;

  logic       clk = 1'b0;
  logic       rstn;
  logic       enable;
  logic       keyPressed;
  logic [1:0] registradores;
  logic       rstnGlobal;
  logic       showWin;
  logic       showLose;
  logic       busy;
  logic [3:0] dutCode;

  int errors = 0;
  int checks = 0;

  end_game_ctrl #(
    .LOSE_HOLD_CYCLES(LH),
    .RST_PULSE_CYCLES(RP),
    .WIN_TIMEOUT_CYCLES(WT)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .enable(enable),
    .keyPressed(keyPressed),
    .registradores(registradores),
    .rstnGlobal(rstnGlobal),
    .showWin(showWin),
    .showLose(showLose),
    .busy(busy)
  );

  always #5 clk = ~clk;

  assign dutCode = {~rstnGlobal, showLose, showWin, busy};

  // Model: a queue of output frames still to be shown; empty means idle.
  logic [3:0] script[$];
  logic [3:0] expCode = C_IDLE;
  logic [3:0] cur;
  logic       keyPrev = 1'b0;
  logic       edgeSeen;
  bit         modelValid = 1'b0;

  always @(posedge clk) begin
    if (!rstn) begin
      script.delete();
      keyPrev    = 1'b0;
      expCode    = C_IDLE;
      modelValid = 1'b1;
    end else begin
      cur      = (script.size() > 0) ? script[0] : C_IDLE;
      expCode  = cur;
      edgeSeen = keyPressed && !keyPrev;
      keyPrev  = keyPressed;
      case (cur)
        C_IDLE: begin
          if (enable && registradores == 2'b10) begin
            repeat (LH) script.push_back(C_LOSE);
            repeat (RP) script.push_back(C_PULSE);
          end else if (enable && registradores == 2'b01) begin
`ifdef END_GAME_AUTO_RESTART_EN
            repeat (WT) script.push_back(C_WIN);
            repeat (RP) script.push_back(C_PULSE);
`else
            script.push_back(C_WIN);
`endif
          end
        end
        C_WIN: begin
          if (!enable) begin
            script.delete();
          end else if (edgeSeen) begin
            script.delete();
            repeat (RP) script.push_back(C_PULSE);
          end else begin
`ifdef END_GAME_AUTO_RESTART_EN
            void'(script.pop_front());
`endif
          end
        end
        C_LOSE: begin
          if (!enable) script.delete();
          else void'(script.pop_front());
        end
        default: void'(script.pop_front());
      endcase
    end
  end

  always @(negedge clk) begin
    if (modelValid) begin
      checks++;
      if (dutCode !== expCode) begin
        errors++;
        $display("[TB] FAIL model_compare t=%0t got=%b expected=%b", $time, dutCode, expCode);
      end
    end
  end

  task automatic applyStimulus(input logic r, input logic e, input logic [1:0] v, input logic k);
    rstn          = r;
    enable        = e;
    registradores = v;
    keyPressed    = k;
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [3:0] actual, input logic [3:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s t=%0t got=%b expected=%b", name, $time, actual, expected);
    end
  endtask

  logic [3:0] loseSeq [12];
  logic [3:0] r4;
  logic       rr;
  logic       re;
  logic       rk;
  logic [1:0] rv;

  initial begin
    loseSeq = '{C_LOSE, C_LOSE, C_LOSE, C_LOSE, C_LOSE,
                C_PULSE, C_PULSE, C_PULSE, C_IDLE, C_IDLE, C_IDLE, C_IDLE};

    // Reset then idle
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b0);
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b0);
    checkOutput("reset_state", dutCode, C_IDLE);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b1, 2'b00, 1'b0);
      checkOutput("idle_no_verdict", dutCode, C_IDLE);
    end

    // Lose path: 5 lose frames, 3 pulse frames, then idle
    applyStimulus(1'b1, 1'b1, 2'b10, 1'b0);
    checkOutput("lose_accept_edge", dutCode, C_IDLE);
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b1, 1'b1, 2'b00, 1'b0);
      checkOutput("lose_sequence", dutCode, loseSeq[i]);
    end

    // Win with key already held: no restart until released and pressed again
    applyStimulus(1'b1, 1'b1, 2'b01, 1'b1);
    checkOutput("win_accept_edge", dutCode, C_IDLE);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b1, 2'b00, 1'b1);
      checkOutput("win_held_key", dutCode, C_WIN);
    end
    applyStimulus(1'b1, 1'b1, 2'b00, 1'b0);
    checkOutput("win_key_released", dutCode, C_WIN);
    applyStimulus(1'b1, 1'b1, 2'b00, 1'b1);
    checkOutput("win_key_edge", dutCode, C_WIN);
    for (int i = 0; i < RP; i++) begin
      applyStimulus(1'b1, 1'b1, 2'b00, 1'b1);
      checkOutput("win_pulse", dutCode, C_PULSE);
    end
    applyStimulus(1'b1, 1'b1, 2'b00, 1'b0);
    checkOutput("win_back_idle", dutCode, C_IDLE);

    // Abort: drop enable two cycles into LOSE_HOLD
    applyStimulus(1'b1, 1'b1, 2'b10, 1'b0);
    applyStimulus(1'b1, 1'b1, 2'b00, 1'b0);
    applyStimulus(1'b1, 1'b1, 2'b00, 1'b0);
    applyStimulus(1'b1, 1'b0, 2'b00, 1'b0);
    checkOutput("abort_last_lose", dutCode, C_LOSE);
    applyStimulus(1'b1, 1'b0, 2'b00, 1'b0);
    checkOutput("abort_idle", dutCode, C_IDLE);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 1'b1, 2'b00, 1'b0);
      checkOutput("abort_no_pulse", dutCode, C_IDLE);
    end

    // Reset in the middle of the restart pulse
    applyStimulus(1'b1, 1'b1, 2'b10, 1'b0);
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b1, 2'b00, 1'b0);
    checkOutput("pulse_before_reset", dutCode, C_PULSE);
    applyStimulus(1'b0, 1'b1, 2'b00, 1'b0);
    checkOutput("reset_mid_pulse", dutCode, C_IDLE);
    applyStimulus(1'b1, 1'b1, 2'b00, 1'b0);

    // Invalid verdict 11 is ignored
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1'b1, 2'b11, 1'b0);
      checkOutput("invalid_verdict", dutCode, C_IDLE);
    end

    // Win with no key press
    applyStimulus(1'b1, 1'b1, 2'b01, 1'b0);
`ifdef END_GAME_AUTO_RESTART_EN
    for (int i = 0; i < WT + RP; i++) begin
      applyStimulus(1'b1, 1'b1, 2'b00, 1'b0);
      checkOutput("auto_restart", dutCode, (i < WT) ? C_WIN : C_PULSE);
    end
    applyStimulus(1'b1, 1'b1, 2'b00, 1'b0);
    checkOutput("auto_restart_idle", dutCode, C_IDLE);
`else
    for (int i = 0; i < 100; i++) begin
      applyStimulus(1'b1, 1'b1, 2'b00, 1'b0);
      checkOutput("win_no_timeout", dutCode, C_WIN);
    end
    applyStimulus(1'b1, 1'b1, 2'b00, 1'b1);
    for (int i = 0; i < RP + 1; i++) begin
      applyStimulus(1'b1, 1'b1, 2'b00, 1'b0);
      checkOutput("win_exit", dutCode, (i < RP) ? C_PULSE : C_IDLE);
    end
`endif

    // Randomized traffic, checked only by the model compare process
    rk = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      rr = ($urandom_range(0, 63) != 0);
      re = ($urandom_range(0, 15) != 0);
      r4 = 4'($urandom_range(0, 15));
      rv = (r4[3:2] == 2'b00) ? r4[1:0] : 2'b00;
      if ($urandom_range(0, 4) == 0) rk = ~rk;
      applyStimulus(rr, re, rv, rk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
